// File: rtl/qcalc_pkg.sv
// Shared definitions for the queue calculator.
//   - Opcode encodings (OP_PUSH .. OP_CLEAR) carried on the 3-bit op input.
//   - Error codes (ERR_NONE .. ERR_DIV0) reported on the 2-bit err_code output.
//   - Control state encoding for the top-level sequencer.
package qcalc_pkg;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_MOD   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } qcalc_state_e;

endpackage

// File: rtl/qcalc_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first quotient bit is produced on the start edge straight from the
// dividend/divisor inputs, so all WIDTH bits are ready after WIDTH edges and
// done pulses for one cycle after that.  Quotient/remainder hold their value
// until the next start.  Requires WIDTH >= 2.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start                load operands and begin a division
//   dividend, divisor    operands sampled on the start edge
//   done                 one-cycle pulse: quotient/remainder are final
//   quotient, remainder  result of dividend / divisor, dividend % divisor
module qcalc_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [CW-1:0]    cnt_q;
  logic             running_q, done_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.  quo doubles as the
  // dividend shift register; quotient bits enter at the LSB.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] trial;
    logic           qbit;
    trial = {rem, quo[WIDTH-1]};
    qbit  = 1'b0;
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      qbit  = 1'b1;
    end
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], qbit};
  endfunction

  always_comb begin
    rem_in = start ? '0       : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor  : dvs_q;
    {rem_d, quo_d} = div_step(rem_in, quo_in, dvs_in);
  end

  // Datapath registers carry no reset; they are only meaningful once done.
  always_ff @(posedge clk) begin
    if (start) dvs_q <= divisor;
    if (start || running_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else if (start) begin
      running_q <= 1'b1;
      cnt_q     <= CW'(1);
      done_q    <= 1'b0;
    end else if (running_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/queue_calc_unit.sv
// Queue-based calculator over a DEPTH-entry circular operand buffer.
// Binary ops consume the two oldest entries (a = oldest, b = next) and append
// the result at the tail.  DIV/MOD run on an iterative divider and hold the
// block busy for WIDTH cycles with the queue frozen.
// Optional build macro QCALC_SAT_EN: ADD/MUL saturate to all-ones and SUB
// clamps to 0 instead of wrapping modulo 2^WIDTH.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   in             PUSH operand
//   op             opcode (see qcalc_pkg)
//   apply          command strobe, taken on a clock edge while ready=1
//   ready / busy   ready = !busy; busy while a DIV/MOD is in progress
//   tail           most recently written entry
//   head           oldest entry, 0 when empty
//   count          entries held; empty / full derived from it
//   valid          low once any error occurred since reset/CLEAR
//   err_code       first error since reset/CLEAR
module queue_calc_unit
  import qcalc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic [2:0]                 op,
  input  logic                       apply,
  output logic                       ready,
  output logic                       busy,
  output logic [WIDTH-1:0]           tail,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       valid,
  output logic [1:0]                 err_code
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  qcalc_state_e     state_q, state_d;
  logic [PW-1:0]    head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic [1:0]       err_q, err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             is_mod_q;

  logic [WIDTH-1:0] op_a, op_b, div_res;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             err_req;
  logic [1:0]       err_val;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Single-cycle ALU for ADD/MUL/SUB; SUB is b - a (newer minus older).
  function automatic logic [WIDTH-1:0] alu(
    input logic [2:0]       opc,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
`ifdef QCALC_SAT_EN
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (opc)
      OP_ADD:  return sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      OP_MUL:  return (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
      OP_SUB:  return (a > b) ? '0 : b - a;
      default: return '0;
    endcase
`else
    case (opc)
      OP_ADD:  return a + b;
      OP_MUL:  return a * b;
      OP_SUB:  return b - a;
      default: return '0;
    endcase
`endif
  endfunction

  assign op_a    = mem_q[head_ptr_q];
  assign op_b    = mem_q[ptr_inc(head_ptr_q)];
  assign div_res = is_mod_q ? div_rem : div_quo;

  qcalc_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (op_b),
    .divisor   (op_a),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    div_start  = 1'b0;
    err_req    = 1'b0;
    err_val    = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (apply) begin
          case (op)
            OP_PUSH: begin
              if (count_q == CW'(DEPTH)) begin
                err_req = 1'b1;
                err_val = ERR_OVF;
              end else begin
                mem_we     = 1'b1;
                mem_wdata  = in;
                tail_ptr_d = ptr_inc(tail_ptr_q);
                count_d    = count_q + 1'b1;
                tail_d     = in;
              end
            end
            OP_POP: begin
              if (count_q == '0) begin
                err_req = 1'b1;
                err_val = ERR_UNF;
              end else begin
                head_ptr_d = ptr_inc(head_ptr_q);
                count_d    = count_q - 1'b1;
              end
            end
            OP_ADD, OP_MUL, OP_SUB: begin
              if (count_q < CW'(2)) begin
                err_req = 1'b1;
                err_val = ERR_UNF;
              end else begin
                // When full, tail_ptr equals head_ptr: the result lands in the
                // slot of a, which is being popped in the same cycle.
                mem_we     = 1'b1;
                mem_wdata  = alu(op, op_a, op_b);
                head_ptr_d = ptr_inc(ptr_inc(head_ptr_q));
                tail_ptr_d = ptr_inc(tail_ptr_q);
                count_d    = count_q - 1'b1;
                tail_d     = mem_wdata;
              end
            end
            OP_DIV, OP_MOD: begin
              if (count_q < CW'(2)) begin
                err_req = 1'b1;
                err_val = ERR_UNF;
              end else if (op_a == '0) begin
                err_req = 1'b1;
                err_val = ERR_DIV0;
              end else begin
                div_start = 1'b1;
                state_d   = ST_DIV;
              end
            end
            default: begin
              head_ptr_d = '0;
              tail_ptr_d = '0;
              count_d    = '0;
              valid_d    = 1'b1;
              err_d      = ERR_NONE;
            end
          endcase
        end
      end
      ST_DIV: begin
        // Queue is frozen while busy, so a and b are still at head.
        if (div_done) begin
          mem_we     = 1'b1;
          mem_wdata  = div_res;
          head_ptr_d = ptr_inc(ptr_inc(head_ptr_q));
          tail_ptr_d = ptr_inc(tail_ptr_q);
          count_d    = count_q - 1'b1;
          tail_d     = div_res;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only the first error since reset/CLEAR is recorded.
    if (err_req) begin
      valid_d = 1'b0;
      if (valid_q) err_d = err_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b1;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is not reset: entries outside [head, head+count) are never read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_ptr_q] <= mem_wdata;
    if (div_start) is_mod_q <= (op == OP_MOD);
  end

  assign busy     = (state_q == ST_DIV);
  assign ready    = !busy;
  assign tail     = tail_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign head     = empty ? '0 : op_a;
  assign valid    = valid_q;
  assign err_code = err_q;

endmodule
